muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit and its sequencing FSM, in the EX stage beside the ALU.

---
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_sequencer.sv | 174 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between decode/EX and the iterative RV32M unit.
// The master side issues ops; the slave side is the unit.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, flush_i, funct3_i,
    output op_a_i, op_b_i,
    input  stall_o, busy_o, done_o,
    input  result_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i,
    input  op_a_i, op_b_i,
    output stall_o, busy_o, done_o,
    output result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 1 bit per cycle shift-add
// multiply and restoring divide, with sign fixup and special cases.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  io
);
  localparam int CW = $clog2(XLEN);
  localparam int AW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] bmag_q, bmag_d;
  logic [2:0]      f3_q, f3_d;
  logic            sa_q, sa_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [XLEN-1:0] min_v;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] spec_res;

  assign min_v = {1'b1, {(XLEN-1){1'b0}}};

  // MULH/DIV/REM treat both operands as signed; MULHSU only rs1
  assign sgn_a = io.op_a_i[XLEN-1] &
                 ((io.funct3_i == 3'b001) |
                  (io.funct3_i == 3'b010) |
                  (io.funct3_i == 3'b100) |
                  (io.funct3_i == 3'b110));
  assign sgn_b = io.op_b_i[XLEN-1] &
                 ((io.funct3_i == 3'b001) |
                  (io.funct3_i == 3'b100) |
                  (io.funct3_i == 3'b110));

  assign a_mag = sgn_a ? (~io.op_a_i + 1'b1) : io.op_a_i;
  assign b_mag = sgn_b ? (~io.op_b_i + 1'b1) : io.op_b_i;

  assign b_zero = (io.op_b_i == '0);
  assign ovf = ~io.funct3_i[0] &
               (io.op_a_i == min_v) &
               (io.op_b_i == '1);
  assign special = io.funct3_i[2] & (b_zero | ovf);

  always_comb begin
    spec_res = '0;
    if (b_zero)
      spec_res = io.funct3_i[1] ? io.op_a_i : '1;
    else
      spec_res = io.funct3_i[1] ? '0 : min_v;
  end

  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_nxt;
  logic [XLEN:0]   div_shl;
  logic [XLEN:0]   div_dif;
  logic [AW-1:0]   div_nxt;

  assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, bmag_q};
  assign mul_nxt = acc_q[0]
                 ? {mul_sum, acc_q[XLEN-1:1]}
                 : {1'b0, acc_q[AW-1:1]};

  // Remainder stays below |b|, so XLEN+1 bits cover the trial subtract
  assign div_shl = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
  assign div_dif = div_shl - {1'b0, bmag_q};
  assign div_nxt = div_dif[XLEN]
                 ? {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                 : {div_dif[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quot, rem;

  assign prod = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quot = neg_q ? (~acc_q[XLEN-1:0] + 1'b1)
                      : acc_q[XLEN-1:0];
  assign rem  = sa_q ? (~acc_q[AW-1:XLEN] + 1'b1)
                     : acc_q[AW-1:XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    f3_d    = f3_q;
    sa_d    = sa_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (io.start_i && !io.flush_i) begin
          f3_d   = io.funct3_i;
          acc_d  = {{XLEN{1'b0}}, a_mag};
          bmag_d = b_mag;
          sa_d   = sgn_a;
          neg_d  = sgn_a ^ sgn_b;
          if (special) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            cnt_d   = CW'(XLEN - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = f3_q[2] ? div_nxt : mul_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0)
          state_d = FIX;
      end
      FIX: begin
        unique case (1'b1)
          (f3_q == 3'b000):
            res_d = prod[XLEN-1:0];
          (!f3_q[2] && f3_q != 3'b000):
            res_d = prod[AW-1:XLEN];
          (f3_q[2] && !f3_q[1]):
            res_d = quot;
          (f3_q[2] && f3_q[1]):
            res_d = rem;
          default:
            res_d = res_q;
        endcase
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush_i) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      f3_q    <= '0;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      f3_q    <= f3_d;
      sa_q    <= sa_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign io.stall_o = ((state_q == IDLE) & io.start_i &
                       ~io.flush_i) |
                      (state_q == CALC) |
                      (state_q == FIX);
  assign io.busy_o   = (state_q != IDLE);
  assign io.done_o   = (state_q == DONE);
  assign io.result_o = res_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a
// 64-bit arithmetic reference of the RV32M rules.
module tb_muldiv_sequencer;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(32)) io ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f3[0] && a == MINV && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b);
    io.start_i  = 1'b1;
    io.funct3_i = f3;
    io.op_a_i   = a;
    io.op_b_i   = b;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    bit sp, seen;
    int n, st;
    exp  = model(f3, a, b);
    sp   = is_special(f3, a, b);
    seen = 1'b0;
    st   = 0;
    @(negedge clk);
    issue(f3, a, b);
    #1 check({tag, "_stall0"}, 32'(io.stall_o), 32'd1);
    @(negedge clk);
    io.start_i  = 1'b0;
    io.funct3_i = 3'($urandom);
    io.op_a_i   = $urandom;
    io.op_b_i   = $urandom;
    #1;
    n = 1;
    while (n < 100) begin
      if (io.done_o) begin
        seen = 1'b1;
        break;
      end
      if (io.stall_o) st++;
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, n, sp ? 32'd1 : 32'd34);
    check({tag, "_stall"}, st, sp ? 32'd0 : 32'd33);
    check({tag, "_res"}, io.result_o, exp);
    last_res = exp;
    @(negedge clk);
    #1 check({tag, "_pulse"}, 32'(io.done_o), 32'd0);
    check({tag, "_hold"}, io.result_o, exp);
  endtask

  task automatic wait_cycles(input int k, output int dones);
    dones = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      #1;
      if (io.done_o) dones++;
    end
  endtask

  initial begin
    int d;
    logic [2:0] f3;
    logic [31:0] a, b;
    io.start_i  = 1'b0;
    io.flush_i  = 1'b0;
    io.funct3_i = '0;
    io.op_a_i   = '0;
    io.op_b_i   = '0;
    #1;
    check("rst_stall", 32'(io.stall_o), 32'd0);
    check("rst_busy", 32'(io.busy_o), 32'd0);
    check("rst_done", 32'(io.done_o), 32'd0);
    check("rst_res", io.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh",   3'd1, MINV, MINV);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",   3'd5, 32'd100, 32'd7);
    run_op("remu",   3'd7, 32'd100, 32'd7);
    run_op("div0",   3'd4, 32'd1234, 32'd0);
    run_op("remu0",  3'd7, 32'd5, 32'd0);
    run_op("divovf", 3'd4, MINV, 32'hFFFF_FFFF);
    run_op("removf", 3'd6, MINV, 32'hFFFF_FFFF);

    @(negedge clk);
    issue(3'd0, 32'd3, 32'd5);
    @(negedge clk);
    io.start_i = 1'b0;
    wait_cycles(10, d);
    io.flush_i = 1'b1;
    @(negedge clk);
    io.flush_i = 1'b0;
    #1;
    check("flush_busy", 32'(io.busy_o), 32'd0);
    check("flush_res", io.result_o, last_res);
    wait_cycles(40, d);
    check("flush_nodone", d, 32'd0);
    run_op("postflush", 3'd5, 32'd1000, 32'd9);

    @(negedge clk);
    issue(3'd0, 32'd11, 32'd13);
    @(negedge clk);
    io.start_i = 1'b0;
    wait_cycles(5, d);
    issue(3'd0, 32'd99, 32'd99);
    @(negedge clk);
    io.start_i = 1'b0;
    wait_cycles(60, d);
    check("busy_start_dones", d, 32'd1);
    check("busy_start_res", io.result_o, 32'd143);

    @(negedge clk);
    issue(3'd4, 32'd500, 32'd3);
    @(negedge clk);
    io.start_i = 1'b0;
    wait_cycles(6, d);
    rst = 1'b1;
    #1;
    check("mrst_res", io.result_o, 32'd0);
    check("mrst_busy", 32'(io.busy_o), 32'd0);
    check("mrst_stall", 32'(io.stall_o), 32'd0);
    check("mrst_done", 32'(io.done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(40, d);
    check("mrst_nodone", d, 32'd0);

    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      run_op("rand", f3, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
